// File: rtl/circular_op_stepper_pkg.sv
// Shared step-direction, FSM-state and quadrant types for the circular stepper.
package circular_op_stepper_pkg;

  // Per-axis step direction; NEG encodes -1 in two's complement
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b11
  } StepDir_t;

  // Stepper control states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INIT = 2'b01,
    STEP = 2'b10,
    DONE = 2'b11
  } StepperState_t;

  // Centre-relative quadrant; the origin is folded into QUAD_1
  typedef enum logic [1:0] {
    QUAD_1 = 2'b00,
    QUAD_2 = 2'b01,
    QUAD_3 = 2'b10,
    QUAD_4 = 2'b11
  } PosQuadrant_t;

endpackage

// File: rtl/circular_step_chooser.sv
// Combinational single-step chooser: decodes the quadrant, forms both candidate
// radial errors and picks the axis whose move keeps |x^2+y^2-r^2| smallest.
module circular_step_chooser
  import circular_op_stepper_pkg::*;
#(
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned ERR_BITS = 2 * NUM_BITS + 3
) (
  input  logic                       is_cw,
  input  logic signed [NUM_BITS-1:0] x,
  input  logic signed [NUM_BITS-1:0] y,
  input  logic signed [ERR_BITS-1:0] err,
  output StepDir_t                   step_x,
  output StepDir_t                   step_y,
  output logic signed [ERR_BITS-1:0] next_err
);

  localparam int unsigned EXT_BITS = ERR_BITS - NUM_BITS;
  localparam logic signed [ERR_BITS-1:0] L_ONE = ERR_BITS'(1);

  logic                       w_x_neg, w_x_zero, w_x_pos;
  logic                       w_y_neg, w_y_zero, w_y_pos;
  PosQuadrant_t               w_quad;
  logic                       w_sx_neg, w_sy_neg;
  logic signed [ERR_BITS-1:0] w_x_ext, w_y_ext;
  logic signed [ERR_BITS-1:0] w_ex, w_ey;
  logic        [ERR_BITS-1:0] w_abs_ex, w_abs_ey;

  assign w_x_neg  = x[NUM_BITS-1];
  assign w_x_zero = (x == '0);
  assign w_x_pos  = !w_x_neg && !w_x_zero;
  assign w_y_neg  = y[NUM_BITS-1];
  assign w_y_zero = (y == '0);
  assign w_y_pos  = !w_y_neg && !w_y_zero;

  assign w_x_ext = $signed({{EXT_BITS{x[NUM_BITS-1]}}, x});
  assign w_y_ext = $signed({{EXT_BITS{y[NUM_BITS-1]}}, y});

  // Quadrant decode, with the origin treated as Q1
  always_comb begin
    w_quad = QUAD_4;
    if ((w_x_pos && !w_y_neg) || (w_x_zero && w_y_zero)) begin
      w_quad = QUAD_1;
    end else if (!w_x_pos && w_y_pos) begin
      w_quad = QUAD_2;
    end else if (w_x_neg && !w_y_pos) begin
      w_quad = QUAD_3;
    end
  end

  // Candidate move signs: CCW table per quadrant, inverted for CW
  always_comb begin
    w_sx_neg = 1'b0;
    w_sy_neg = 1'b0;
    case (w_quad)
      QUAD_1:  begin w_sx_neg = 1'b1; w_sy_neg = 1'b0; end
      QUAD_2:  begin w_sx_neg = 1'b1; w_sy_neg = 1'b1; end
      QUAD_3:  begin w_sx_neg = 1'b0; w_sy_neg = 1'b1; end
      default: begin w_sx_neg = 1'b0; w_sy_neg = 1'b0; end
    endcase
    w_sx_neg = w_sx_neg ^ is_cw;
    w_sy_neg = w_sy_neg ^ is_cw;
  end

  // Radial error after each candidate: err + 2*s*coord + 1
  always_comb begin
    w_ex = w_sx_neg ? (err - (w_x_ext <<< 1) + L_ONE) : (err + (w_x_ext <<< 1) + L_ONE);
    w_ey = w_sy_neg ? (err - (w_y_ext <<< 1) + L_ONE) : (err + (w_y_ext <<< 1) + L_ONE);
    w_abs_ex = w_ex[ERR_BITS-1] ? ERR_BITS'(-w_ex) : ERR_BITS'(w_ex);
    w_abs_ey = w_ey[ERR_BITS-1] ? ERR_BITS'(-w_ey) : ERR_BITS'(w_ey);
  end

  // Axis selection; ties go to X
  always_comb begin
    step_x   = DIR_NONE;
    step_y   = DIR_NONE;
    next_err = w_ey;
    if (w_abs_ex <= w_abs_ey) begin
      step_x   = w_sx_neg ? DIR_NEG : DIR_POS;
      next_err = w_ex;
    end else begin
      step_y   = w_sy_neg ? DIR_NEG : DIR_POS;
    end
  end

endmodule

// File: rtl/circular_op_stepper.sv
// Circular arc stepper: accepts one arc command and emits num_steps taxicab
// unit steps over a valid/ready handshake, tracking the centre-relative position.
module circular_op_stepper
  import circular_op_stepper_pkg::*;
#(
  parameter  int unsigned NUM_BITS  = 8,
  localparam int unsigned STEP_BITS = NUM_BITS + 3,
  localparam int unsigned ERR_BITS  = 2 * NUM_BITS + 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        is_cw,
  input  logic signed [NUM_BITS-1:0]  start_x,
  input  logic signed [NUM_BITS-1:0]  start_y,
  input  logic        [NUM_BITS-1:0]  r,
  input  logic        [STEP_BITS-1:0] num_steps,
  output logic                        step_valid,
  input  logic                        step_ready,
  output StepDir_t                    step_x,
  output StepDir_t                    step_y,
  output logic signed [NUM_BITS-1:0]  cur_x,
  output logic signed [NUM_BITS-1:0]  cur_y,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned EXT_BITS = ERR_BITS - NUM_BITS;

  StepperState_t              r_state, w_next_state;
  logic                       r_is_cw;
  logic        [NUM_BITS-1:0] r_radius;
  logic       [STEP_BITS-1:0] r_count;
  logic signed [ERR_BITS-1:0] r_err;
  logic signed [NUM_BITS-1:0] r_cur_x, r_cur_y;

  StepDir_t                   w_step_x, w_step_y;
  logic signed [ERR_BITS-1:0] w_next_err;
  logic signed [ERR_BITS-1:0] w_x_ext, w_y_ext, w_r_ext, w_init_err;
  logic signed [NUM_BITS-1:0] w_next_x, w_next_y;
  logic                       w_handshake;

  circular_step_chooser #(
    .NUM_BITS (NUM_BITS),
    .ERR_BITS (ERR_BITS)
  ) u_chooser (
    .is_cw    (r_is_cw),
    .x        (r_cur_x),
    .y        (r_cur_y),
    .err      (r_err),
    .step_x   (w_step_x),
    .step_y   (w_step_y),
    .next_err (w_next_err)
  );

  // Starting radial error from the freshly loaded position and radius
  always_comb begin
    w_x_ext    = $signed({{EXT_BITS{r_cur_x[NUM_BITS-1]}}, r_cur_x});
    w_y_ext    = $signed({{EXT_BITS{r_cur_y[NUM_BITS-1]}}, r_cur_y});
    w_r_ext    = $signed({{EXT_BITS{1'b0}}, r_radius});
    w_init_err = (w_x_ext * w_x_ext) + (w_y_ext * w_y_ext) - (w_r_ext * w_r_ext);
  end

  // Position after applying the chosen unit step
  always_comb begin
    w_next_x = r_cur_x;
    w_next_y = r_cur_y;
    case (w_step_x)
      DIR_POS: w_next_x = r_cur_x + NUM_BITS'(1);
      DIR_NEG: w_next_x = r_cur_x - NUM_BITS'(1);
      default: w_next_x = r_cur_x;
    endcase
    case (w_step_y)
      DIR_POS: w_next_y = r_cur_y + NUM_BITS'(1);
      DIR_NEG: w_next_y = r_cur_y - NUM_BITS'(1);
      default: w_next_y = r_cur_y;
    endcase
  end

  assign w_handshake = (r_state == STEP) && step_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control outputs
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    step_valid   = 1'b0;
    step_x       = DIR_NONE;
    step_y       = DIR_NONE;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_next_state = INIT;
        end
      end
      INIT: begin
        w_next_state = (r_count == '0) ? DONE : STEP;
      end
      STEP: begin
        step_valid = 1'b1;
        step_x     = w_step_x;
        step_y     = w_step_y;
        if (step_ready && (r_count == STEP_BITS'(1))) begin
          w_next_state = DONE;
        end
      end
      default: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
    endcase
  end

  // Command latch, error init and per-step datapath update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_cw  <= 1'b0;
      r_radius <= '0;
      r_count  <= '0;
      r_err    <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
    end else begin
      if ((r_state == IDLE) && cmd_valid) begin
        r_is_cw  <= is_cw;
        r_radius <= r;
        r_count  <= num_steps;
        r_cur_x  <= start_x;
        r_cur_y  <= start_y;
      end else if (r_state == INIT) begin
        r_err <= w_init_err;
      end else if (w_handshake) begin
        r_cur_x <= w_next_x;
        r_cur_y <= w_next_y;
        r_err   <= w_next_err;
        r_count <= r_count - STEP_BITS'(1);
      end
    end
  end

  assign cur_x = r_cur_x;
  assign cur_y = r_cur_y;

endmodule

// File: tb/tb_circular_op_stepper.sv
// Self-checking bench for circular_op_stepper against a geometric reference model.
module tb_circular_op_stepper;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        is_cw;
  logic [7:0]  start_x, start_y, r;
  logic [10:0] num_steps;
  logic        step_valid;
  logic        step_ready;
  logic [1:0]  step_x, step_y;
  logic [7:0]  cur_x, cur_y;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  circular_op_stepper #(.NUM_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .is_cw      (is_cw),
    .start_x    (start_x),
    .start_y    (start_y),
    .r          (r),
    .num_steps  (num_steps),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_x     (step_x),
    .step_y     (step_y),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: choose the move whose resulting |x^2+y^2-r^2| is smallest
  function automatic void model_step(input int x, input int y, input int rad, input bit cw,
                                     output int dx, output int dy);
    int q, cdx, cdy, ex, ey, aex, aey;
    if ((x > 0 && y >= 0) || (x == 0 && y == 0)) q = 1;
    else if (x <= 0 && y > 0) q = 2;
    else if (x < 0 && y <= 0) q = 3;
    else q = 4;
    cdx = (q == 1 || q == 2) ? -1 : 1;
    cdy = (q == 1 || q == 4) ? 1 : -1;
    if (cw) begin
      cdx = -cdx;
      cdy = -cdy;
    end
    ex  = (x + cdx) * (x + cdx) + y * y - rad * rad;
    ey  = x * x + (y + cdy) * (y + cdy) - rad * rad;
    aex = (ex < 0) ? -ex : ex;
    aey = (ey < 0) ? -ey : ey;
    if (aex <= aey) begin
      dx = cdx;
      dy = 0;
    end else begin
      dx = 0;
      dy = cdy;
    end
  endfunction

  function automatic logic [1:0] dir_code(input int d);
    if (d > 0) return 2'b01;
    if (d < 0) return 2'b11;
    return 2'b00;
  endfunction

  // Issue one arc and follow it to done, checking every cycle against the model.
  // mode 0: always ready; 1: random ready plus ignored command noise; 2: stall 5 cycles on 3rd step
  task automatic run_arc(input bit cw, input int sx, input int sy, input int rad, input int n,
                         input int mode, output int res_x, output int res_y, output int done_cyc,
                         output int c_xp, output int c_xn, output int c_yp, output int c_yn);
    int mx, my, cyc, hs, last_hs, stall, dx, dy, want;
    bit fin;
    logic [1:0] ex_sx, ex_sy;
    logic [7:0] ex_cx, ex_cy;
    mx = sx; my = sy; hs = 0; last_hs = 0; stall = 0; fin = 0;
    done_cyc = -1; res_x = 0; res_y = 0;
    c_xp = 0; c_xn = 0; c_yp = 0; c_yn = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    is_cw = cw; start_x = 8'(sx); start_y = 8'(sy); r = 8'(rad);
    num_steps = 11'(n); cmd_valid = 1'b1; step_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_accept: busy=%b cmd_ready=%b want 1/0", busy, cmd_ready);
    end
    while (!fin && cyc < 4000) begin
      case (mode)
        0: step_ready = 1'b1;
        1: step_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (hs == 2 && stall < 5) begin
            step_ready = 1'b0;
            stall++;
          end else begin
            step_ready = 1'b1;
          end
        end
      endcase
      if (mode == 1 && done !== 1'b1) begin
        cmd_valid = 1'($urandom_range(0, 1));
        start_x   = 8'($urandom);
        start_y   = 8'($urandom);
        r         = 8'($urandom);
        num_steps = 11'($urandom);
        is_cw     = 1'($urandom_range(0, 1));
      end else begin
        cmd_valid = 1'b0;
      end
      ex_cx = 8'(mx);
      ex_cy = 8'(my);
      checks++;
      if (cur_x !== ex_cx || cur_y !== ex_cy) begin
        errors++;
        $display("FAIL cur_pos cyc=%0d: got (%0d,%0d) want (%0d,%0d)", cyc,
                 $signed(cur_x), $signed(cur_y), mx, my);
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        done_cyc = cyc;
        res_x = int'($signed(cur_x));
        res_y = int'($signed(cur_y));
        want = (n == 0) ? 2 : last_hs + 1;
        checks++;
        if (cyc != want) begin
          errors++;
          $display("FAIL done_cycle: got %0d want %0d", cyc, want);
        end
        checks++;
        if (hs != n || step_valid !== 1'b0) begin
          errors++;
          $display("FAIL done_state: steps=%0d valid=%b want %0d/0", hs, step_valid, n);
        end
      end else if (cyc == 1 || hs >= n) begin
        checks++;
        if (step_valid !== 1'b0) begin
          errors++;
          $display("FAIL step_valid_idle cyc=%0d: got %b want 0", cyc, step_valid);
        end
      end else begin
        checks++;
        if (step_valid !== 1'b1) begin
          errors++;
          $display("FAIL step_valid cyc=%0d: got %b want 1", cyc, step_valid);
        end
        model_step(mx, my, rad, cw, dx, dy);
        ex_sx = dir_code(dx);
        ex_sy = dir_code(dy);
        checks++;
        if (step_x !== ex_sx || step_y !== ex_sy) begin
          errors++;
          $display("FAIL step_dir step=%0d at (%0d,%0d): got x=%b y=%b want x=%b y=%b",
                   hs, mx, my, step_x, step_y, ex_sx, ex_sy);
        end
        if (step_ready) begin
          hs++;
          last_hs = cyc;
          mx += dx;
          my += dy;
          if (dx > 0) c_xp++;
          if (dx < 0) c_xn++;
          if (dy > 0) c_yp++;
          if (dy < 0) c_yn++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    step_ready = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL arc_timeout: no done after %0d cycles, steps=%0d want %0d", cyc, hs, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; is_cw = 1'b0; start_x = '0; start_y = '0;
    r = '0; num_steps = '0; step_ready = 1'b0;
    #2;
    checks++;
    if (cmd_ready !== 1'b1 || step_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        step_x !== 2'b00 || step_y !== 2'b00 || cur_x !== 8'h00 || cur_y !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: rdy=%b v=%b busy=%b done=%b sx=%b sy=%b cur=(%0d,%0d)",
               cmd_ready, step_valid, busy, done, step_x, step_y, cur_x, cur_y);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ccw_quarter();
    int fx, fy, dc, xp, xn, yp, yn;
    run_arc(1'b0, 4, 0, 4, 8, 0, fx, fy, dc, xp, xn, yp, yn);
    checks++;
    if (xn != 4 || yp != 4 || xp != 0 || yn != 0) begin
      errors++;
      $display("FAIL ccw_counts: xn=%0d yp=%0d xp=%0d yn=%0d want 4/4/0/0", xn, yp, xp, yn);
    end
    checks++;
    if (fx != 0 || fy != 4) begin
      errors++;
      $display("FAIL ccw_end: got (%0d,%0d) want (0,4)", fx, fy);
    end
    checks++;
    if (dc != 10) begin
      errors++;
      $display("FAIL ccw_latency: done at T+%0d want T+10", dc);
    end
  endtask

  task automatic test_full_circle();
    int fx, fy, dc, xp, xn, yp, yn;
    run_arc(1'b0, 2, 0, 2, 16, 0, fx, fy, dc, xp, xn, yp, yn);
    checks++;
    if (fx != 2 || fy != 0 || xp != xn || yp != yn || (xp + xn + yp + yn) != 16) begin
      errors++;
      $display("FAIL full_circle: end (%0d,%0d) xp=%0d xn=%0d yp=%0d yn=%0d want (2,0) balanced 16",
               fx, fy, xp, xn, yp, yn);
    end
  endtask

  task automatic test_cw_quarter();
    int fx, fy, dc, xp, xn, yp, yn;
    run_arc(1'b1, 0, 3, 3, 6, 0, fx, fy, dc, xp, xn, yp, yn);
    checks++;
    if (xp != 3 || yn != 3 || fx != 3 || fy != 0) begin
      errors++;
      $display("FAIL cw_quarter: xp=%0d yn=%0d end (%0d,%0d) want 3/3 (3,0)", xp, yn, fx, fy);
    end
  endtask

  task automatic test_zero_steps();
    int fx, fy, dc, xp, xn, yp, yn;
    run_arc(1'b0, 5, 0, 5, 0, 0, fx, fy, dc, xp, xn, yp, yn);
    checks++;
    if (dc != 2 || (xp + xn + yp + yn) != 0) begin
      errors++;
      $display("FAIL zero_steps: done at T+%0d steps=%0d want T+2 and 0", dc, xp + xn + yp + yn);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_ready_T3: rdy=%b busy=%b done=%b want 1/0/0", cmd_ready, busy, done);
    end
  endtask

  task automatic test_backpressure();
    int fx, fy, dc, xp, xn, yp, yn;
    run_arc(1'b0, 4, 0, 4, 8, 2, fx, fy, dc, xp, xn, yp, yn);
    checks++;
    if ((xp + xn + yp + yn) != 8 || fx != 0 || fy != 4 || dc != 15) begin
      errors++;
      $display("FAIL backpressure: steps=%0d end (%0d,%0d) done T+%0d want 8 (0,4) T+15",
               xp + xn + yp + yn, fx, fy, dc);
    end
  endtask

  task automatic test_reset_mid_arc();
    int hs, cyc, fx, fy, dc, xp, xn, yp, yn;
    bit saw_done;
    hs = 0; cyc = 0; saw_done = 1'b0;
    @(negedge clk);
    is_cw = 1'b0; start_x = 8'd4; start_y = 8'd0; r = 8'd4; num_steps = 11'd8;
    cmd_valid = 1'b1; step_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (hs < 3 && cyc < 50) begin
      if (step_valid === 1'b1) hs++;
      @(negedge clk);
      cyc++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || step_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        step_x !== 2'b00 || step_y !== 2'b00 || cur_x !== 8'h00 || cur_y !== 8'h00) begin
      errors++;
      $display("FAIL mid_arc_reset: hs=%0d rdy=%b v=%b busy=%b done=%b cur=(%0d,%0d)",
               hs, cmd_ready, step_valid, busy, done, cur_x, cur_y);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_arc_no_done: got a done pulse want none");
    end
    run_arc(1'b0, 1, 0, 1, 4, 0, fx, fy, dc, xp, xn, yp, yn);
    checks++;
    if (fx != -1 || fy != 0) begin
      errors++;
      $display("FAIL post_reset_arc: got (%0d,%0d) want (-1,0)", fx, fy);
    end
  endtask

  task automatic test_random_arcs();
    int fx, fy, dc, xp, xn, yp, yn, rad, n, pick, sx, sy;
    bit cw;
    for (int k = 0; k < 8; k++) begin
      rad  = $urandom_range(1, 15);
      n    = $urandom_range(0, 8 * rad);
      pick = $urandom_range(0, 3);
      cw   = 1'($urandom_range(0, 1));
      sx   = (pick == 0) ? rad : (pick == 2) ? -rad : 0;
      sy   = (pick == 1) ? rad : (pick == 3) ? -rad : 0;
      run_arc(cw, sx, sy, rad, n, 1, fx, fy, dc, xp, xn, yp, yn);
      checks++;
      if ((xp + xn + yp + yn) != n) begin
        errors++;
        $display("FAIL random_count arc=%0d: got %0d want %0d", k, xp + xn + yp + yn, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ccw_quarter();
    test_full_circle();
    test_cw_quarter();
    test_zero_steps();
    test_backpressure();
    test_reset_mid_arc();
    test_random_arcs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/circular_op_stepper.md
Name: circular_op_stepper

Overview:
- Walks a circular arc one unit step at a time: consumes an arc command (centre-relative start point, radius, direction, pre-computed step count) and emits one ±1 X or Y step per output handshake.
- Sits between the circular-op step-count calculation and the motor/step-output stage in the processor.
- Uses taxicab stepping: each step moves exactly one axis by one unit. The axis is chosen to minimise radial error |x²+y²−r²|.

Parameters:
- NUM_BITS, 8, width of signed coordinates and radius.
- STEP_BITS, NUM_BITS+3, width of the step counter (max 8·r); localparam.
- ERR_BITS, 2*NUM_BITS+3, width of the signed radial-error register; localparam.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- is_cw  in  1  clockwise rotation when 1.
- start_x  in  NUM_BITS  signed start X, relative to centre.
- start_y  in  NUM_BITS  signed start Y, relative to centre.
- r  in  NUM_BITS  radius, non-negative.
- num_steps  in  STEP_BITS  total steps to emit.
- step_valid  out  1  a step is offered.
- step_ready  in  1  consumer takes the step.
- step_x  out  2  StepDir_t for X.
- step_y  out  2  StepDir_t for Y.
- cur_x  out  NUM_BITS  current relative X, after the last accepted step.
- cur_y  out  NUM_BITS  current relative Y, after the last accepted step.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (reset=0, async): state=IDLE, cmd_ready=1, step_valid=0, step_x=step_y=DIR_NONE, cur_x=cur_y=0, busy=0, done=0, counter=0, error=0. Reset mid-operation aborts the arc immediately; no done pulse is produced.
- FSM: IDLE -> INIT -> STEP -> DONE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch is_cw, r, num_steps; load cur_x/cur_y from start_x/start_y; go to INIT.
- INIT (1 cycle):
  - err = start_x² + start_y² − r², computed in ERR_BITS signed.
  - If counter==0, go to DONE; else go to STEP.
- STEP:
  - step_valid=1; step_x/step_y come from the chooser on the registered cur_x, cur_y, err.
  - Outputs are stable while step_valid&!step_ready.
  - On handshake: cur += step, err updated, counter−1. If the counter was 1, go to DONE; else stay in STEP, so back-to-back steps are possible every cycle.
- DONE (1 cycle): done=1, step_valid=0; go to IDLE. cmd_ready is asserted in the following cycle.
- Latency: command accepted in cycle T; first step_valid in T+2; done pulse in the cycle after the last step handshake. With num_steps=0, done is at T+2.
- Quadrant convention (centre-relative):
  - Q1: x>0, y>=0.
  - Q2: x<=0, y>0.
  - Q3: x<0, y<=0.
  - Q4: x>=0, y<0.
  - (0,0) counts as Q1.
- Candidate moves, CCW:
  - Q1: X−1 or Y+1.
  - Q2: X−1 or Y−1.
  - Q3: X+1 or Y−1.
  - Q4: X+1 or Y+1.
- CW negates every candidate sign.
- Selection:
  - eX = err + 2·sx·x + 1.
  - eY = err + 2·sy·y + 1.
  - Take the X move if |eX| <= |eY| (tie prefers X); else the Y move.
  - The non-chosen axis outputs DIR_NONE. Exactly one axis is non-NONE per step.
- Error update: err <= chosen eX or eY. No saturation; the ERR_BITS width guarantees no overflow for |x|,|y| <= r+1.
- Axis crossing: the quadrant is recomputed every step from cur_x/cur_y, so wrap past any axis (and full circles) needs no special case.
- Step count: exactly num_steps handshakes occur, regardless of where the path ends.
- cmd_valid outside IDLE is ignored; the command is not latched.

Decomposition:
- Step_PKG holds:
  - StepDir_t (2-bit enum): DIR_NONE=2'b00, DIR_POS=2'b01, DIR_NEG=2'b11.
  - StepperState_t: IDLE, INIT, STEP, DONE.
- Quadrant typedef/constants come from Position_PKG (PosQuadrant_t).
- Sub-module circular_step_chooser (combinational): inputs is_cw, x, y, err; outputs step_x, step_y, next_err. This isolates quadrant decode and error arithmetic from the FSM and allows unit testing.

Test Plan:
- CCW quarter: r=4, start (4,0), num_steps=8, is_cw=0, step_ready=1 -> exactly 8 steps (4×X NEG, 4×Y POS); cur ends at (0,4); done at cycle T+10.
- Full circle: r=2, start (2,0), num_steps=16, is_cw=0 -> 16 steps; final cur (2,0); net displacement 0 per axis; every step crosses axes correctly.
- CW quarter: r=3, start (0,3), num_steps=6, is_cw=1 -> first step X POS; 3×X POS and 3×Y NEG; cur ends at (3,0).
- Zero steps: num_steps=0 -> step_valid never asserted; done pulses at T+2; cmd_ready high at T+3.
- Backpressure: r=4 CCW, step_ready held low 5 cycles on the 3rd step -> step_valid, step_x, step_y, cur_x/cur_y stable for those cycles; total step count is still 8.
- Reset mid-arc: assert reset=0 after step 3 of 8 -> all outputs at reset values immediately and asynchronously; no done pulse; after release a new command (r=1, start (1,0), 4 steps CCW) ends at (−1,0).
